// File: rtl/trace_term_monitor.sv
// trace_term_monitor: watches per-core retirement traces, records each core's
// exit (l.nop 0x1) with its r3 exit code, and raises sticky completion,
// failure and watchdog-timeout status. The only control states are the sticky
// flags: RUN until all_done (DONE) or timeout (TIMEOUT), both held until rst.
module trace_term_monitor #(
    parameter int                   NUM_CORES      = 9,
    parameter logic [NUM_CORES-1:0] CORE_MASK      = '1,
    parameter logic [31:0]          EXIT_INSN      = 32'h15000001,
    parameter int                   TIMEOUT_CYCLES = 1000000,
    parameter int                   CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    trace_valid,
    input  logic [NUM_CORES*32-1:0] trace_insn,
    input  logic [NUM_CORES*32-1:0] trace_r3,
    output logic [NUM_CORES-1:0]    term_vec,
    output logic                    all_done,
    output logic                    fail,
    output logic [5:0]              fail_id,
    output logic [31:0]             fail_code,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    done_cycles,
    output logic [6:0]              exit_count
);

    localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT =
        WD_ON ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic [NUM_CORES-1:0] live_ret;   // retirement from a still-running core
    logic [NUM_CORES-1:0] exit_ev;    // first exit of a core this cycle
    logic [NUM_CORES-1:0] term_next;
    logic [6:0]           n_exit;
    logic                 fail_hit;
    logic [5:0]           fail_idx;
    logic [31:0]          fail_r3;
    logic                 done_hit;
    logic                 wd_fire;
    logic                 cyc_max;
    logic [CNT_WIDTH-1:0] cyc;
    logic [CNT_WIDTH-1:0] wd;

    // Per-core exit detection, exit popcount and lowest-index failure encoder.
    always_comb begin
        live_ret = '0;
        exit_ev  = '0;
        n_exit   = '0;
        fail_hit = 1'b0;
        fail_idx = '0;
        fail_r3  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            live_ret[i] = trace_valid[i] & ~term_vec[i];
            exit_ev[i]  = live_ret[i] && (trace_insn[32*i +: 32] == EXIT_INSN);
            n_exit      = n_exit + 7'(exit_ev[i]);
        end
        // Scan downwards so the lowest failing index is the one left standing.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (exit_ev[i] && (trace_r3[32*i +: 32] != 32'h0)) begin
                fail_hit = 1'b1;
                fail_idx = 6'(i);
                fail_r3  = trace_r3[32*i +: 32];
            end
        end
    end

    // Completion and watchdog decisions; completion outranks a same-cycle timeout.
    always_comb begin
        term_next = term_vec | exit_ev;
        done_hit  = !all_done && ((term_next & CORE_MASK) == CORE_MASK);
        cyc_max   = &cyc;
        wd_fire   = WD_ON && !all_done && !timeout && !done_hit &&
                    !(|live_ret) && (wd == WD_LIMIT);
    end

    // Sticky per-core termination flags and exit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_vec   <= '0;
            exit_count <= '0;
        end else begin
            term_vec   <= term_next;
            exit_count <= exit_count + n_exit;
        end
    end

    // First failure latch; later failures leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_id   <= '0;
            fail_code <= '0;
        end else if (!fail && fail_hit) begin
            fail      <= 1'b1;
            fail_id   <= fail_idx;
            fail_code <= fail_r3;
        end
    end

    // Completion flag and completion timestamp (saturating like the counter).
    always_ff @(posedge clk) begin
        if (rst) begin
            all_done    <= 1'b0;
            done_cycles <= '0;
        end else if (done_hit) begin
            all_done    <= 1'b1;
            done_cycles <= cyc_max ? cyc : cyc + 1'b1;
        end
    end

    // Saturating cycle counter, halted once the run has ended either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= '0;
        end else if (!all_done && !timeout && !cyc_max) begin
            cyc <= cyc + 1'b1;
        end
    end

    // Watchdog: live retirements clear it, silence counts towards the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            if (WD_ON && !all_done && !timeout) begin
                if (|live_ret) begin
                    wd <= '0;
                end else if (wd != WD_LIMIT) begin
                    wd <= wd + 1'b1;
                end
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
